fft_wr_addr_gen: RTL and testbench
==================================

FFT_WR_ADDR_GEN -- requirements
Module: fft_wr_addr_gen

Interface
REQ-001 Parameter N_LOG2, default 7, shall set FFT size 2^N_LOG2 (128 points, 7 layers, 64 butterflies per layer).
REQ-002 Parameter DW, default 16, shall set the width of each real and imaginary component.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins write-back sequencing for a new transform.
REQ-006 in_valid  input  1  butterfly result pair is present on in_a/in_b.
REQ-007 in_ready  output  1  block accepts a result pair this cycle.
REQ-008 in_a, in_b  input  2*DW each  butterfly upper/lower outputs, {re, im}.
REQ-009 wr_en  output  1  RAM write strobe for both ports.
REQ-010 wr_addr_a, wr_addr_b  output  N_LOG2 each  in-place write addresses.
REQ-011 wr_data_a, wr_data_b  output  2*DW each  registered copies of in_a/in_b.
REQ-012 layer_cnt  output  3  current layer, 0..6.
REQ-013 layer_done  output  1  one-cycle pulse after the last pair of a layer is written.
REQ-014 fft_done  output  1  one-cycle pulse after the last pair of layer 6 is written.
REQ-015 busy  output  1  high in RUN.

Function
REQ-016 States: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE on accepting layer 6, butterfly 63; DONE->IDLE unconditionally next cycle.
REQ-017 in_ready shall equal (state==RUN); a transfer occurs when in_valid && in_ready.
REQ-018 Internal bf_cnt (6 bits) shall increment per transfer; at 63 it shall wrap to 0 and layer_cnt shall increment.
REQ-019 For layer L and butterfly b: half=2^L; wr_addr_a = ((b>>L)<<(L+1)) | (b & (half-1)); wr_addr_b = wr_addr_a + half.
REQ-020 Addresses shall be identical to the read addresses the read-side generator issued for the same (L, b), so the transform remains in place.
REQ-021 wr_en, addresses and data shall be registered: they appear exactly one cycle after the transfer; wr_en is high for one cycle per transfer.
REQ-022 With in_valid low in RUN, counters shall hold and wr_en shall be 0 the next cycle (stall tolerance, no bubbles inserted).
REQ-023 layer_done shall assert in the same cycle as the wr_en of butterfly 63 of each layer, including layer 6.
REQ-024 fft_done shall assert in the same cycle as the final wr_en (layer 6, b 63); busy shall be 0 in that cycle.
REQ-025 start while in RUN or DONE shall be ignored.
REQ-026 in_valid in IDLE/DONE shall be ignored; no write issued.
REQ-027 On entering RUN, layer_cnt and bf_cnt shall be 0.

Reset
REQ-028 rst_n low shall asynchronously force state IDLE, layer_cnt 0, bf_cnt 0, and all outputs 0 (wr_en, addresses, data, layer_done, fft_done, busy, in_ready).
REQ-029 Reset asserted mid-transform shall abandon it; no write shall issue after reset deasserts until a new start.

Structure
REQ-030 A shared fft package shall hold N_LOG2, DW, the state encoding, and the address function of REQ-019, used by both read- and write-side generators.
REQ-031 One sub-module, fft_bf_addr, shall compute (L, b) -> (addr_a, addr_b) combinationally; this block instantiates it once.

Verification
REQ-032 start, then layer 0 b 0 transferred -> next cycle wr_en=1, wr_addr_a=0, wr_addr_b=1.
REQ-033 Layer 2 b 5 -> wr_addr_a=9, wr_addr_b=13; layer 3 b 9 -> 17, 25.
REQ-034 Layer 6 b 5 -> 5, 69; layer 6 b 63 -> 63, 127 with layer_done=1, fft_done=1, then state IDLE.
REQ-035 448 back-to-back transfers -> 448 writes, 7 layer_done pulses, 1 fft_done; every address 0..127 written exactly once per layer.
REQ-036 Random in_valid gaps plus start pulses during RUN -> address sequence identical to back-to-back case, starts ignored.
REQ-037 rst_n low at layer 4 b 30 -> all outputs 0 immediately; new start restarts at layer 0 b 0 with addresses 0, 1.

Source files
------------

// File: rtl/fft_wr_addr_gen_pkg.sv
// Shared FFT definitions: default sizes, controller state encoding and the
// in-place butterfly address function used by read- and write-side generators.
package fft_wr_addr_gen_pkg;

  localparam int unsigned DEF_N_LOG2 = 7;
  localparam int unsigned DEF_DW     = 16;
  localparam int unsigned LAYER_W    = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Upper address of butterfly bf in layer: insert a 0 bit at position layer.
  function automatic int unsigned bf_addr_a(input int unsigned layer,
                                            input int unsigned bf);
    int unsigned half;
    half = 32'd1 << layer;
    return ((bf >> layer) << (layer + 32'd1)) | (bf & (half - 32'd1));
  endfunction

endpackage

// File: rtl/fft_bf_addr.sv
// Combinational (layer, butterfly) -> in-place RAM address pair.
//   layer    : current FFT layer
//   bf       : butterfly index within the layer
//   addr_a_c : upper operand address
//   addr_b_c : lower operand address (addr_a_c + 2^layer)
module fft_bf_addr
  import fft_wr_addr_gen_pkg::*;
#(
  parameter int unsigned N_LOG2 = DEF_N_LOG2
) (
  input  logic [LAYER_W-1:0] layer,
  input  logic [N_LOG2-2:0]  bf,
  output logic [N_LOG2-1:0]  addr_a_c,
  output logic [N_LOG2-1:0]  addr_b_c
);

  localparam int unsigned AW = N_LOG2;

  always_comb begin
    addr_a_c = AW'(bf_addr_a(32'(layer), 32'(bf)));
    addr_b_c = addr_a_c + (AW'(1) << layer);
  end

endmodule

// File: rtl/fft_wr_addr_gen.sv
// FFT write-back address generator: accepts butterfly result pairs, issues
// registered in-place RAM writes and tracks layer / transform completion.
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a new transform (honoured in IDLE only)
//   in_valid/in_ready     : result pair handshake
//   in_a, in_b            : butterfly upper/lower results {re, im}
//   wr_en                 : RAM write strobe (both ports)
//   wr_addr_a/b, wr_data_a/b : write address / data pairs
//   layer_cnt             : current layer
//   layer_done, fft_done  : completion pulses aligned with the last write
//   busy                  : transform in progress
module fft_wr_addr_gen
  import fft_wr_addr_gen_pkg::*;
#(
  parameter int unsigned N_LOG2 = DEF_N_LOG2,
  parameter int unsigned DW     = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*DW-1:0]      in_a,
  input  logic [2*DW-1:0]      in_b,
  output logic                 wr_en,
  output logic [N_LOG2-1:0]    wr_addr_a,
  output logic [N_LOG2-1:0]    wr_addr_b,
  output logic [2*DW-1:0]      wr_data_a,
  output logic [2*DW-1:0]      wr_data_b,
  output logic [LAYER_W-1:0]   layer_cnt,
  output logic                 layer_done,
  output logic                 fft_done,
  output logic                 busy
);

  localparam int unsigned BW = N_LOG2 - 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [BW-1:0]     bf_cnt;
  logic              xfer;
  logic              bf_last;
  logic              layer_last;
  logic [N_LOG2-1:0] addr_a_c;
  logic [N_LOG2-1:0] addr_b_c;

  // Decodes of the state register; no combinational input paths.
  assign in_ready   = (state == ST_RUN);
  assign busy       = (state == ST_RUN);
  assign xfer       = in_valid && (state == ST_RUN);
  assign bf_last    = &bf_cnt;
  assign layer_last = (layer_cnt == LAYER_W'(N_LOG2 - 1));

  fft_bf_addr #(
    .N_LOG2 (N_LOG2)
  ) u_bf_addr (
    .layer    (layer_cnt),
    .bf       (bf_cnt),
    .addr_a_c (addr_a_c),
    .addr_b_c (addr_b_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (xfer && bf_last && layer_last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Butterfly / layer counters; cleared on entry to RUN, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bf_cnt    <= '0;
      layer_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      bf_cnt    <= '0;
      layer_cnt <= '0;
    end else if (xfer) begin
      if (bf_last) begin
        bf_cnt    <= '0;
        layer_cnt <= layer_last ? '0 : layer_cnt + LAYER_W'(1);
      end else begin
        bf_cnt <= bf_cnt + BW'(1);
      end
    end
  end

  // Write port: one registered write per accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr_a  <= '0;
      wr_addr_b  <= '0;
      wr_data_a  <= '0;
      wr_data_b  <= '0;
      layer_done <= 1'b0;
      fft_done   <= 1'b0;
    end else begin
      wr_en      <= xfer;
      layer_done <= xfer && bf_last;
      fft_done   <= xfer && bf_last && layer_last;
      if (xfer) begin
        wr_addr_a <= addr_a_c;
        wr_addr_b <= addr_b_c;
        wr_data_a <= in_a;
        wr_data_b <= in_b;
      end
    end
  end

endmodule

// File: tb/tb_fft_wr_addr_gen.sv
// Directed bench for fft_wr_addr_gen: reset, idle handshake, full transforms
// with and without stalls / stray starts, and mid-transform reset.
module tb_fft_wr_addr_gen;

  localparam int unsigned NLAYER = 7;
  localparam int unsigned NPTS   = 128;
  localparam int unsigned NXFER  = 448;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        wr_en;
  logic [6:0]  wr_addr_a;
  logic [6:0]  wr_addr_b;
  logic [31:0] wr_data_a;
  logic [31:0] wr_data_b;
  logic [2:0]  layer_cnt;
  logic        layer_done;
  logic        fft_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_hits[NLAYER][NPTS];
  int n_writes;
  int n_ldone;
  int n_fdone;

  fft_wr_addr_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .wr_en      (wr_en),
    .wr_addr_a  (wr_addr_a),
    .wr_addr_b  (wr_addr_b),
    .wr_data_a  (wr_data_a),
    .wr_data_b  (wr_data_b),
    .layer_cnt  (layer_cnt),
    .layer_done (layer_done),
    .fft_done   (fft_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address: split b at bit l and open a gap of one layer span.
  function automatic int unsigned exp_addr_a(input int unsigned l, input int unsigned b);
    int unsigned half;
    half = 1 << l;
    return (b / half) * (2 * half) + (b % half);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"},      64'(wr_en),      64'd0);
    check({tag, "_addr_a"},     64'(wr_addr_a),  64'd0);
    check({tag, "_addr_b"},     64'(wr_addr_b),  64'd0);
    check({tag, "_data_a"},     64'(wr_data_a),  64'd0);
    check({tag, "_data_b"},     64'(wr_data_b),  64'd0);
    check({tag, "_layer_cnt"},  64'(layer_cnt),  64'd0);
    check({tag, "_layer_done"}, 64'(layer_done), 64'd0);
    check({tag, "_fft_done"},   64'(fft_done),   64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_in_ready"},   64'(in_ready),   64'd0);
  endtask

  // Start a transform and push stop_at pairs; every accepted pair is checked
  // one cycle later against the reference address / data.
  task automatic run_fft(input bit gaps, input bit noise, input int stop_at);
    int          cnt;
    int          l;
    int          b;
    int          cycles;
    bit          v;
    logic [31:0] da;
    logic [31:0] db;
    int unsigned ea;

    for (int i = 0; i < NLAYER; i++)
      for (int j = 0; j < NPTS; j++) wr_hits[i][j] = 0;
    n_writes = 0;
    n_ldone  = 0;
    n_fdone  = 0;

    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    check("run_in_ready", 64'(in_ready),  64'd1);
    check("run_busy",     64'(busy),      64'd1);
    check("run_layer0",   64'(layer_cnt), 64'd0);
    check("run_wr_en0",   64'(wr_en),     64'd0);

    cnt = 0; l = 0; b = 0; cycles = 0;
    while (cnt < stop_at && cycles < 4000) begin
      v  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      da = {16'(cnt), 16'(cnt ^ 16'hA5C3)};
      db = $urandom();
      in_valid = v;
      in_a = da;
      in_b = db;
      start = noise && ($urandom_range(0, 7) == 0);
      tick();
      cycles++;
      if (wr_en)      n_writes++;
      if (layer_done) n_ldone++;
      if (fft_done)   n_fdone++;
      if (v) begin
        ea = exp_addr_a(l, b);
        check("wr_en",      64'(wr_en),      64'd1);
        check("addr_a",     64'(wr_addr_a),  64'(ea));
        check("addr_b",     64'(wr_addr_b),  64'(ea + (1 << l)));
        check("data_a",     64'(wr_data_a),  64'(da));
        check("data_b",     64'(wr_data_b),  64'(db));
        check("layer_done", 64'(layer_done), 64'(b == 63));
        check("fft_done",   64'(fft_done),   64'(l == 6 && b == 63));
        if (l == 0 && b == 0)  begin check("l0b0_a", 64'(wr_addr_a), 64'd0);  check("l0b0_b", 64'(wr_addr_b), 64'd1);   end
        if (l == 2 && b == 5)  begin check("l2b5_a", 64'(wr_addr_a), 64'd9);  check("l2b5_b", 64'(wr_addr_b), 64'd13);  end
        if (l == 3 && b == 9)  begin check("l3b9_a", 64'(wr_addr_a), 64'd17); check("l3b9_b", 64'(wr_addr_b), 64'd25);  end
        if (l == 6 && b == 5)  begin check("l6b5_a", 64'(wr_addr_a), 64'd5);  check("l6b5_b", 64'(wr_addr_b), 64'd69);  end
        if (l == 6 && b == 63) begin check("l6b63_a", 64'(wr_addr_a), 64'd63); check("l6b63_b", 64'(wr_addr_b), 64'd127); end
        wr_hits[l][int'(wr_addr_a)]++;
        wr_hits[l][int'(wr_addr_b)]++;
        cnt++;
        if (b == 63) begin b = 0; l++; end
        else b++;
      end else begin
        check("stall_wr_en",      64'(wr_en),      64'd0);
        check("stall_layer_done", 64'(layer_done), 64'd0);
      end
      if (cnt < int'(NXFER)) begin
        check("busy_run",  64'(busy),      64'd1);
        check("layer_cnt", 64'(layer_cnt), 64'(l));
      end else begin
        check("busy_done", 64'(busy), 64'd0);
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("run_count", 64'(cnt), 64'(stop_at));

    if (stop_at == int'(NXFER)) begin
      // DONE: in_valid and start must both be ignored
      in_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("done_wr_en",    64'(wr_en),    64'd0);
      check("done_fft_done", 64'(fft_done), 64'd0);
      check("idle_in_ready", 64'(in_ready), 64'd0);
      check("idle_busy",     64'(busy),     64'd0);
      tick();
      check("idle_wr_en",     64'(wr_en),    64'd0);
      check("idle_no_restart", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      for (int i = 0; i < NLAYER; i++) begin
        int once;
        once = 0;
        for (int j = 0; j < NPTS; j++) if (wr_hits[i][j] == 1) once++;
        check($sformatf("layer%0d_cover", i), 64'(once), 64'(NPTS));
      end
      check("n_writes",     64'(n_writes), 64'(NXFER));
      check("n_layer_done", 64'(n_ldone),  64'd7);
      check("n_fft_done",   64'(n_fdone),  64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    #1;
    check_zero("rst");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_zero("post_rst");

    // in_valid while idle is ignored
    in_valid = 1'b1;
    in_a = 32'h1234_5678;
    tick();
    check("idle_valid_wr_en", 64'(wr_en),    64'd0);
    check("idle_valid_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    tick();

    run_fft(1'b0, 1'b0, NXFER);
    run_fft(1'b1, 1'b1, NXFER);

    // Reset at layer 4, butterfly 30
    run_fft(1'b0, 1'b0, 4 * 64 + 30);
    check("pre_rst_wr_en", 64'(wr_en), 64'd1);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    check_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check("after_rst_wr_en", 64'(wr_en), 64'd0);
    tick();
    check("after_rst_wr_en2", 64'(wr_en),    64'd0);
    check("after_rst_ready",  64'(in_ready), 64'd0);
    in_valid = 1'b0;
    run_fft(1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
